// File: rtl/adder_pkg.sv
// Shared types and the three-operand slice-sum helper for the chunked adder family.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } add_state_t;

  // Widest slice any adder in the family may use; narrower slices are zero-extended.
  localparam int MAX_CHUNK = 32;

  // Sum of three slices plus a 2-bit carry; the 2 extra result bits never overflow.
  function automatic logic [MAX_CHUNK+1:0] sum3_slice(
    input logic [MAX_CHUNK-1:0] x,
    input logic [MAX_CHUNK-1:0] y,
    input logic [MAX_CHUNK-1:0] z,
    input logic [1:0]           carry
  );
    return {2'b00, x} + {2'b00, y} + {2'b00, z} + {{MAX_CHUNK{1'b0}}, carry};
  endfunction

endpackage

// File: rtl/chunk_adder3.sv
// Combinational CHUNK-bit three-operand slice adder; the slice is picked by cnt.
module chunk_adder3
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int CW    = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [CW-1:0]    cnt,
  input  logic [1:0]       carry,
  output logic [CHUNK-1:0] sum,
  output logic [1:0]       carry_n
);

  logic [MAX_CHUNK-1:0] a_s, b_s, c_s;
  logic [MAX_CHUNK+1:0] full;
  logic [31:0]          base;

  always_comb begin
    a_s  = '0;
    b_s  = '0;
    c_s  = '0;
    base = 32'(cnt) * CHUNK;
    a_s[CHUNK-1:0] = a[base +: CHUNK];
    b_s[CHUNK-1:0] = b[base +: CHUNK];
    c_s[CHUNK-1:0] = c[base +: CHUNK];
    full = sum3_slice(a_s, b_s, c_s, carry);
    {carry_n, sum} = (CHUNK+2)'(full);
  end

endmodule

// File: rtl/chunked_adder3.sv
// Multi-cycle a+b+c adder, CHUNK bits per clock, valid/ready on both sides.
// Optional build macro CHUNKED_ADDER3_SAT_EN saturates the sum on overflow.
module chunked_adder3
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_sum,
  output logic             out_ovf,
  output add_state_t       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE, and neither depends on
  // the opposite side's signal in the same cycle.

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  add_state_t       state_q, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [WIDTH+1:0] result_q, result_nxt;
  logic [1:0]       carry_q, carry_n;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;
  logic             last;
  logic [CHUNK-1:0] slice_sum;

  chunk_adder3 #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK),
    .CW   (CW)
  ) u_slice (
    .a      (a_q),
    .b      (b_q),
    .c      (c_q),
    .cnt    (cnt_q),
    .carry  (carry_q),
    .sum    (slice_sum),
    .carry_n(carry_n)
  );

  assign last = (cnt_q == LAST);

  always_comb begin
    state_nxt = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Merge the current slice into the result; the final slice also lands the carry-out.
  always_comb begin
    result_nxt = result_q;
    result_nxt[32'(cnt_q) * CHUNK +: CHUNK] = slice_sum;
    if (last) result_nxt[WIDTH+1:WIDTH] = carry_n;
`ifdef CHUNKED_ADDER3_SAT_EN
    if (last && (carry_n != 2'b00)) result_nxt = {2'b00, {WIDTH{1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 2'b00;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      unique case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          c_q     <= c;
          cnt_q   <= '0;
          carry_q <= 2'b00;
        end
        BUSY: begin
          result_q <= result_nxt;
          carry_q  <= carry_n;
          cnt_q    <= cnt_q + CW'(1);
          if (last) ovf_q <= |carry_n;
        end
        default: ;
      endcase
    end
  end

  assign out_sum   = result_q;
  assign out_ovf   = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_chunked_adder3.sv
// Bench for chunked_adder3: directed vector table, back-pressure and reset corners,
// back-to-back random traffic, and narrower configurations (12/3 and 8/8).
module tb_chunked_adder3;
  import adder_pkg::*;

`ifdef CHUNKED_ADDER3_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT 16/4
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_ovf;
  logic [15:0] a = '0, b = '0, c = '0;
  logic [17:0] out_sum;
  add_state_t  dbg_state;

  chunked_adder3 #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .dbg_state(dbg_state)
  );

  // 12/3 DUT
  logic        iv12 = 1'b0, ir12, ov12, f12;
  logic [11:0] a12 = '0, b12 = '0, c12 = '0;
  logic [13:0] s12;
  add_state_t  st12;

  chunked_adder3 #(.WIDTH(12), .CHUNK(3)) dut12 (
    .clk(clk), .rst(rst), .in_valid(iv12), .in_ready(ir12),
    .a(a12), .b(b12), .c(c12), .out_valid(ov12), .out_ready(1'b1),
    .out_sum(s12), .out_ovf(f12), .dbg_state(st12)
  );

  // 8/8 DUT (single-chunk)
  logic        iv8 = 1'b0, ir8, ov8, f8;
  logic [7:0]  a8 = '0, b8 = '0, c8 = '0;
  logic [9:0]  s8;
  add_state_t  st8;

  chunked_adder3 #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .c(c8), .out_valid(ov8), .out_ready(1'b1),
    .out_sum(s8), .out_ovf(f8), .dbg_state(st8)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [18:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] sat16(input logic [17:0] x);
    return (SAT && (x[17:16] != 2'b00)) ? 18'h0FFFF : x;
  endfunction

  function automatic logic [18:0] model16(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    logic [17:0] s;
    s = 18'(x) + 18'(y) + 18'(z);
    return {(s[17:16] != 2'b00), sat16(s)};
  endfunction

  // Observes both handshakes of the main DUT away from the clock edge.
  always @(negedge clk) begin
    logic [18:0] e;
    if (rst) exp_q.delete();
    else begin
      if (in_valid && in_ready) exp_q.push_back(model16(a, b, c));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected_output", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("sb_result", 32'({out_ovf, out_sum}), 32'(e));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Entered and left at #1 after a rising edge; returns once out_valid is seen.
  task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] ic,
                       output logic [17:0] s, output logic ovf, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    in_valid = 1'b1; a = ia; b = ib; c = ic;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    s = out_sum; ovf = out_ovf;
  endtask

  typedef struct {
    logic [15:0] a, b, c;
    logic [17:0] sum;
    logic        ovf;
  } vec_t;

  localparam int NV = 10;
  vec_t vec[NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] s;
    logic        ovf;
    int          lat, guard;
    logic [13:0] e12;
    logic [9:0]  e8;

    vec[0] = '{16'h1234, 16'h0001, 16'h0000, 18'h01235, 1'b0};
    vec[1] = '{16'hAAAA, 16'h5555, 16'h0001, sat16(18'h10000), 1'b1};
    vec[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, sat16(18'h2FFFD), 1'b1};
    vec[3] = '{16'h0000, 16'h0000, 16'h0000, 18'h00000, 1'b0};
    vec[4] = '{16'hFFFF, 16'h0000, 16'h0000, 18'h0FFFF, 1'b0};
    vec[5] = '{16'hFFFF, 16'h0001, 16'h0000, sat16(18'h10000), 1'b1};
    vec[6] = '{16'h8000, 16'h8000, 16'h8000, sat16(18'h18000), 1'b1};
    vec[7] = '{16'h0F0F, 16'hF0F0, 16'h0000, 18'h0FFFF, 1'b0};
    vec[8] = '{16'h5555, 16'h5555, 16'h5555, 18'h0FFFF, 1'b0};
    vec[9] = '{16'h1111, 16'h2222, 16'h3333, 18'h06666, 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    check("reset_flags", 32'({in_ready, out_valid, out_ovf}), 32'(3'b100));
    check("reset_sum", 32'(out_sum), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed vector table
    for (int i = 0; i < NV; i++) begin
      do_op(vec[i].a, vec[i].b, vec[i].c, s, ovf, lat);
      check($sformatf("vec%0d_sum", i), 32'(s), 32'(vec[i].sum));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vec[i].ovf));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      @(posedge clk); #1;
      check($sformatf("vec%0d_back_to_idle", i), 32'({out_valid, in_ready}), 32'(2'b01));
    end

    // back-pressure held in DONE
    out_ready = 1'b0;
    do_op(16'h0F00, 16'h00F0, 16'h000F, s, ovf, lat);
    check("bp_sum", 32'(s), 32'h00FFF);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", k), 32'({out_valid, in_ready, out_sum}), 32'({1'b1, 1'b0, 18'h00FFF}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 32'({out_valid, in_ready}), 32'(2'b01));

    // reset on the second BUSY cycle discards the transaction
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; c = 16'hFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    check("mid_rst_flags", 32'({in_ready, out_valid}), 32'(2'b10));
    check("mid_rst_sum", 32'(out_sum), 32'd0);
    guard = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) guard++;
    end
    check("mid_rst_no_output", 32'(guard), 32'd0);

    // back-to-back random traffic with in_valid held high
    in_valid = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      c = 16'($urandom_range(0, 65535));
      guard = 0;
      while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
      if (guard >= 50) begin
        check("rand_accept_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // WIDTH=12 / CHUNK=3
    for (int n = 0; n < 200; n++) begin
      a12 = 12'($urandom_range(0, 4095));
      b12 = 12'($urandom_range(0, 4095));
      c12 = 12'($urandom_range(0, 4095));
      if (n == 0) begin a12 = 12'hFFF; b12 = 12'hFFF; c12 = 12'hFFF; end
      e12 = 14'(a12) + 14'(b12) + 14'(c12);
      ovf = (e12[13:12] != 2'b00);
      if (SAT && ovf) e12 = 14'h0FFF;
      guard = 0;
      while (!ir12 && guard < 50) begin @(posedge clk); #1; guard++; end
      iv12 = 1'b1;
      @(posedge clk); #1;
      iv12 = 1'b0;
      lat = 0;
      while (!ov12 && lat < 50) begin @(posedge clk); #1; lat++; end
      check($sformatf("w12_sum%0d", n), 32'(s12), 32'(e12));
      check($sformatf("w12_ovf%0d", n), 32'(f12), 32'(ovf));
      check($sformatf("w12_latency%0d", n), 32'(lat), 32'd4);
      @(posedge clk); #1;
    end

    // WIDTH=8 / CHUNK=8: single BUSY cycle
    for (int n = 0; n < 200; n++) begin
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      c8 = 8'($urandom_range(0, 255));
      if (n == 0) begin a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF; end
      e8 = 10'(a8) + 10'(b8) + 10'(c8);
      ovf = (e8[9:8] != 2'b00);
      if (SAT && ovf) e8 = 10'h0FF;
      guard = 0;
      while (!ir8 && guard < 50) begin @(posedge clk); #1; guard++; end
      iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      lat = 0;
      while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
      check($sformatf("w8_sum%0d", n), 32'(s8), 32'(e8));
      check($sformatf("w8_ovf%0d", n), 32'(f8), 32'(ovf));
      check($sformatf("w8_latency%0d", n), 32'(lat), 32'd1);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
